// File: rtl/chip8_blit_pkg.sv
// rtl/chip8_blit_pkg.sv - shared types, screen constants and pixel placement for chip8_blitter (BLIT_WRAP_EN selects wrap vs clip)
package chip8_blit_pkg;

    localparam int SCREEN_W    = 128;
    localparam int SCREEN_H    = 64;
    localparam int WIDE_ROWS   = 16;
    localparam int NARROW_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_PIX,
        ST_PIX_WR,
        ST_DONE
    } blit_state_t;

    typedef struct packed {
        logic       visible;
        logic [6:0] hpos;
        logic [5:0] vpos;
    } pix_pos_t;

    // Carry bits of the untruncated sums tell whether a pixel fell off the right/bottom edge.
    function automatic pix_pos_t pixel_pos(input logic [6:0] x, input logic [5:0] y,
                                           input logic [3:0] col, input logic [3:0] row);
        logic [7:0] px;
        logic [6:0] py;
        pix_pos_t   p;
        px     = {1'b0, x} + {4'b0000, col};
        py     = {1'b0, y} + {3'b000, row};
        p.hpos = px[6:0];
        p.vpos = py[5:0];
`ifdef BLIT_WRAP_EN
        p.visible = 1'b1;
`else
        p.visible = !px[7] && !py[6];
`endif
        return p;
    endfunction

endpackage

// File: rtl/chip8_blitter.sv
// rtl/chip8_blitter.sv - CHIP-8/SCHIP sprite blitter: fetch rows from RAM, XOR planes into 2bpp VRAM (BLIT_WRAP_EN: wrap at edges)
module chip8_blitter
    import chip8_blit_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] sprite_addr,
    input  logic [6:0]        sprite_x,
    input  logic [5:0]        sprite_y,
    input  logic [3:0]        sprite_rows,
    input  logic [1:0]        plane,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic [6:0]        vram_hpos,
    output logic [5:0]        vram_vpos,
    input  logic [1:0]        vram_pixelo,
    output logic [1:0]        vram_pixeli,
    output logic              vram_we
);

    blit_state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [6:0]        x_q;
    logic [5:0]        y_q;
    logic [3:0]        n_q;
    logic [1:0]        plane_q;
    logic [3:0]        row;
    logic [3:0]        col;
    logic              byte_sel;
    logic [15:0]       shreg;
    logic              coll_q;

    logic              wide;
    logic              last_col;
    logic              last_row;
    logic              pix_bit;
    logic              draw_pix;
    logic              advance;
    logic [4:0]        ram_off;
    pix_pos_t          pos;
    blit_state_t       adv_state;

    assign wide     = (n_q == 4'd0);
    assign last_col = wide ? (col == 4'(WIDE_ROWS - 1)) : (col == 4'(NARROW_BITS - 1));
    assign last_row = wide ? (row == 4'(WIDE_ROWS - 1)) : (row == n_q - 4'd1);
    assign pos      = pixel_pos(x_q, y_q, col, row);
    // Both widths are left-aligned in shreg, so column c is always bit 15-c.
    assign pix_bit  = shreg[4'd15 - col];
    assign draw_pix = pix_bit && pos.visible && (plane_q != 2'b00);
    assign advance  = (state == ST_PIX_WR) || ((state == ST_PIX) && !draw_pix);
    assign adv_state = last_col ? (last_row ? ST_DONE : ST_FETCH) : ST_PIX;

    assign ram_off  = wide ? {row, byte_sel} : {1'b0, row};
    assign ram_addr = addr_q + {{(ADDR_W-5){1'b0}}, ram_off};

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign vram_we     = (state == ST_PIX_WR);
    assign vram_hpos   = pos.hpos;
    assign vram_vpos   = pos.vpos;
    assign vram_pixeli = vram_we ? (vram_pixelo ^ plane_q) : 2'b00;
    assign collision   = coll_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_FETCH;
            ST_FETCH:  state_nxt = ST_LATCH;
            ST_LATCH:  state_nxt = (wide && !byte_sel) ? ST_FETCH : ST_PIX;
            ST_PIX:    state_nxt = draw_pix ? ST_PIX_WR : adv_state;
            ST_PIX_WR: state_nxt = adv_state;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            n_q      <= '0;
            plane_q  <= '0;
            row      <= '0;
            col      <= '0;
            byte_sel <= 1'b0;
            shreg    <= '0;
            coll_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                addr_q   <= sprite_addr;
                x_q      <= sprite_x;
                y_q      <= sprite_y;
                n_q      <= sprite_rows;
                plane_q  <= plane;
                row      <= '0;
                col      <= '0;
                byte_sel <= 1'b0;
                coll_q   <= 1'b0;
            end
            if (state == ST_LATCH) begin
                if (byte_sel) begin
                    shreg[7:0] <= ram_dout;
                end else begin
                    shreg <= {ram_dout, 8'h00};
                end
                if (wide && !byte_sel) begin
                    byte_sel <= 1'b1;
                end
            end
            if (state == ST_PIX_WR && (vram_pixelo & plane_q) != 2'b00) begin
                coll_q <= 1'b1;
            end
            if (advance) begin
                if (last_col) begin
                    col      <= '0;
                    row      <= row + 4'd1;
                    byte_sel <= 1'b0;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chip8_blitter.sv
// tb/tb_chip8_blitter.sv - scoreboard bench for chip8_blitter with RAM/VRAM models and a sprite reference model
module tb_chip8_blitter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] sprite_addr = '0;
    logic [6:0]  sprite_x = '0;
    logic [5:0]  sprite_y = '0;
    logic [3:0]  sprite_rows = '0;
    logic [1:0]  plane = '0;
    logic        busy, done, collision, vram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_dout = '0;
    logic [6:0]  vram_hpos;
    logic [5:0]  vram_vpos;
    logic [1:0]  vram_pixelo = '0;
    logic [1:0]  vram_pixeli;

    chip8_blitter #(.ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .start(start), .sprite_addr(sprite_addr),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_rows(sprite_rows), .plane(plane),
        .busy(busy), .done(done), .collision(collision), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .vram_hpos(vram_hpos), .vram_vpos(vram_vpos),
        .vram_pixelo(vram_pixelo), .vram_pixeli(vram_pixeli), .vram_we(vram_we)
    );

    always #5 clk = ~clk;

    logic [7:0] ram  [0:4095];
    logic [1:0] vmem [0:63][0:127];
    logic [1:0] refv [0:63][0:127];

    always @(posedge clk) begin
        ram_dout    <= ram[ram_addr];
        vram_pixelo <= vmem[vram_vpos][vram_hpos];
        if (vram_we) vmem[vram_vpos][vram_hpos] <= vram_pixeli;
    end

    typedef struct { int h; int v; int d; } wr_t;
    typedef struct { int lat; int coll; } done_t;
    wr_t   exp_w[$];
    done_t exp_d[$];
    wr_t   mw;
    done_t md;

    int n_checks = 0, n_fail = 0;
    int ncyc = 0, t0 = 0, done_cnt = 0, busy_gap = 0, wr_cnt = 0;
    bit in_draw = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            if (in_draw && !busy) busy_gap++;
            if (vram_we) begin
                wr_cnt++;
                check("write_expected", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) begin
                    mw = exp_w.pop_front();
                    check("wr_hpos", vram_hpos, mw.h);
                    check("wr_vpos", vram_vpos, mw.v);
                    check("wr_data", vram_pixeli, mw.d);
                end
            end
            if (done) begin
                done_cnt++;
                in_draw = 0;
                check("done_expected", exp_d.size() > 0, 1);
                if (exp_d.size() > 0) begin
                    md = exp_d.pop_front();
                    check("done_latency", ncyc - t0, md.lat);
                    check("collision", collision, md.coll);
                    check("writes_pending_at_done", exp_w.size(), 0);
                end
            end
        end
    end

    // Walks the sprite row by row, pixel by pixel, applying the draw rules to a shadow screen.
    task automatic predict(input int addr, input int x, input int y, input int n, input int pl);
        int rows, width, lat, coll, bits, px, py, old;
        bit vis;
        width = (n == 0) ? 16 : 8;
        rows  = (n == 0) ? 16 : n;
        lat = 1;
        coll = 0;
        for (int r = 0; r < rows; r++) begin
            lat += (n == 0) ? 4 : 2;
            if (n == 0)
                bits = (int'(ram[(addr + 2*r) & 4095]) << 8) | int'(ram[(addr + 2*r + 1) & 4095]);
            else
                bits = int'(ram[(addr + r) & 4095]);
            for (int c = 0; c < width; c++) begin
                px = x + c;
                py = y + r;
`ifdef BLIT_WRAP_EN
                px = px % 128;
                py = py % 64;
                vis = 1;
`else
                vis = (px < 128) && (py < 64);
`endif
                if (((bits >> (width - 1 - c)) & 1) == 1 && pl != 0 && vis) begin
                    lat += 2;
                    old = int'(refv[py][px]);
                    if ((old & pl) != 0) coll = 1;
                    refv[py][px] = 2'((old ^ pl) & 3);
                    exp_w.push_back('{px, py, (old ^ pl) & 3});
                end else begin
                    lat += 1;
                end
            end
        end
        exp_d.push_back('{lat, coll});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
        check("idle_timeout", busy, 0);
    endtask

    task automatic launch(input int addr, input int x, input int y, input int n, input int pl);
        wait_idle();
        @(negedge clk);
        #1;
        predict(addr, x, y, n, pl);
        sprite_addr = 12'(addr);
        sprite_x    = 7'(x);
        sprite_y    = 6'(y);
        sprite_rows = 4'(n);
        plane       = 2'(pl);
        start       = 1'b1;
        t0          = ncyc;
        busy_gap    = 0;
        @(posedge clk);
        #1;
        start   = 1'b0;
        in_draw = 1;
    endtask

    task automatic run_draw(input int addr, input int x, input int y, input int n, input int pl,
                            input bit extra);
        int dc0;
        dc0 = done_cnt;
        launch(addr, x, y, n, pl);
        if (extra) begin
            repeat (3) @(negedge clk);
            sprite_x = ~sprite_x;
            plane    = ~plane;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
        end
        for (int i = 0; i < 6000 && in_draw; i++) @(negedge clk);
        check("draw_timeout", in_draw, 0);
        @(negedge clk);
        @(negedge clk);
        check("done_pulses", done_cnt - dc0, 1);
        check("busy_gap", busy_gap, 0);
    endtask

    task automatic clear_screens();
        for (int v = 0; v < 64; v++)
            for (int h = 0; h < 128; h++) begin
                vmem[v][h] = 2'b00;
                refv[v][h] = 2'b00;
            end
    endtask

    int wr0;
    int ra, rx, ry, rn, rp;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        clear_screens();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_collision", collision, 0);
        check("rst_we", vram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_hpos", vram_hpos, 0);
        check("rst_vpos", vram_vpos, 0);
        check("rst_pixeli", vram_pixeli, 0);
        reset = 1'b1;

        ram[12'h200] = 8'h80;
        wr0 = wr_cnt;
        run_draw(12'h200, 10, 5, 1, 1, 0);
        check("s1_writes", wr_cnt - wr0, 1);
        check("s1_pixel", vmem[5][10], 1);
        run_draw(12'h200, 10, 5, 1, 1, 0);
        check("s2_pixel", vmem[5][10], 0);

        for (int i = 12'h300; i < 12'h320; i++) ram[i] = 8'hFF;
        wr0 = wr_cnt;
        run_draw(12'h300, 0, 0, 0, 3, 0);
        check("s3_writes", wr_cnt - wr0, 256);

        for (int i = 12'h400; i < 12'h404; i++) ram[i] = 8'hFF;
        wr0 = wr_cnt;
        run_draw(12'h400, 124, 62, 4, 2, 0);
`ifdef BLIT_WRAP_EN
        check("s4_writes", wr_cnt - wr0, 32);
`else
        check("s4_writes", wr_cnt - wr0, 8);
`endif

        launch(12'h300, 0, 0, 0, 3);
        for (int i = 0; i < 100 && !vram_we; i++) @(negedge clk);
        check("s5_reached_pix_wr", vram_we, 1);
        reset   = 1'b0;
        in_draw = 0;
        #1;
        check("s5_we", vram_we, 0);
        check("s5_busy", busy, 0);
        check("s5_collision", collision, 0);
        exp_w.delete();
        exp_d.delete();
        @(negedge clk);
        clear_screens();
        @(negedge clk);
        reset = 1'b1;
        run_draw(12'h200, 10, 5, 1, 1, 0);
        check("s5_redraw_pixel", vmem[5][10], 1);

        run_draw(12'h200, 10, 5, 1, 1, 1);
        wr0 = wr_cnt;
        run_draw(12'h300, 3, 3, 0, 0, 0);
        check("s6_plane0_writes", wr_cnt - wr0, 0);

        for (int t = 0; t < 20; t++) begin
            ra = $urandom_range(0, 4095);
            for (int k = 0; k < 32; k++) ram[(ra + k) & 4095] = 8'($urandom);
            rx = $urandom_range(0, 127);
            ry = $urandom_range(0, 63);
            rn = $urandom_range(0, 15);
            rp = $urandom_range(0, 3);
            run_draw(ra, rx, ry, rn, rp, bit'($urandom_range(0, 1)));
        end

        check("final_writes_pending", exp_w.size(), 0);
        check("final_dones_pending", exp_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_blitter.md
Name: chip8_blitter

Overview:
- Sprite draw engine (CHIP-8 DXYN / SCHIP DXY0) that writes the 2-bit-per-pixel 128x64 VRAM, the writer end of the frame buffer the display scan path reads.
- Fetches sprite rows from RAM.
- XORs the selected plane(s) into VRAM through read-modify-write.
- Reports collision.
- Sits between the CPU execute stage (start/done handshake) and the VRAM CPU-side port.

Parameters:
- SCREEN_W, 128, VRAM width in pixels (hpos 7 bits).
- SCREEN_H, 64, VRAM height in pixels (vpos 6 bits).
- ADDR_W, 12, RAM address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  draw request; sampled only in IDLE.
- sprite_addr  in  ADDR_W  I register; first sprite byte.
- sprite_x  in  7  left column.
- sprite_y  in  6  top row.
- sprite_rows  in  4  N; 1-15 gives N rows x 8 bits; 0 gives 16 rows x 16 bits.
- plane  in  2  plane mask XORed into each set pixel.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse at completion.
- collision  out  1  sticky result (VF); valid from done until the next accepted start.
- ram_addr  out  ADDR_W  sprite byte address.
- ram_dout  in  8  RAM data; synchronous read, valid 1 cycle after ram_addr.
- vram_hpos  out  7  pixel column.
- vram_vpos  out  6  pixel row.
- vram_pixelo  in  2  VRAM read data; valid 1 cycle after address.
- vram_pixeli  out  2  VRAM write data.
- vram_we  out  1  VRAM write strobe.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - busy, done, collision, vram_we go to 0.
  - ram_addr, vram_hpos, vram_vpos, vram_pixeli go to 0.
  - Reset mid-draw abandons the draw; VRAM keeps any pixels already written.
- States: IDLE, FETCH, LATCH, PIX, PIX_WR, DONE.
- IDLE:
  - start=1 latches all inputs.
  - Clears collision and sets row=0, byte=0, col=0.
  - Goes to FETCH.
  - start while not IDLE is ignored.
- FETCH (1 cycle):
  - 8-wide: ram_addr = sprite_addr + row.
  - 16-wide: ram_addr = sprite_addr + 2*row + byte.
  - All address arithmetic is mod 2^ADDR_W.
- LATCH (1 cycle): captures ram_dout into the row shift register; MSB is the leftmost pixel.
  - 16-wide with byte=0: go back to FETCH with byte=1; the second byte forms the low 8 bits.
  - Otherwise: go to PIX.
- PIX (1 cycle per column):
  - Pixel position px = sprite_x + col, py = sprite_y + row.
  - Bit clear, off-screen (px>=128 or py>=64 before truncation), or plane=0: no VRAM access; advance col.
  - Otherwise: drive vram_hpos/vram_vpos with vram_we=0; go to PIX_WR.
- PIX_WR (1 cycle):
  - vram_pixeli = vram_pixelo ^ plane, with vram_we=1 and the same address.
  - If (vram_pixelo & plane) != 0, set collision.
  - Advance col.
- Column/row advance:
  - After the last column (7 or 15), row increments and goes to FETCH.
  - After the last row, go to DONE.
- DONE: done=1 and busy=1 for one cycle; then IDLE with busy=0.
- Timing:
  - Set on-screen bit costs 2 cycles; any other bit costs 1.
  - Each row costs 2 fetch cycles (8-wide) or 4 (16-wide).
- vram_we is high only in PIX_WR.

Optional Feature:
- BLIT_WRAP_EN defined: off-screen pixels wrap instead of clipping.
  - px mod 128, py mod 64; every set bit is drawn.
- BLIT_WRAP_EN undefined: clipping as described above.
- The start coordinates themselves always fit the port widths, so they always wrap inherently.

Decomposition:
- Package chip8_blit_pkg holds:
  - State enum.
  - SCREEN_W/SCREEN_H constants.
  - WIDE_ROWS=16 and NARROW_BITS=8.
  - Function computing on-screen/wrapped coordinates.
- No sub-module is needed; a single FSM plus datapath is the natural structure.

Test Plan:
1. Cleared VRAM; sprite_addr=0x200, RAM[0x200]=0x80, x=10, y=5, N=1, plane=01; start. Required response:
   - Exactly one write: (10,5) gets 01.
   - done 12 cycles after start accept.
   - collision=0.
2. Repeat scenario 1 with no reset. Required response:
   - (10,5) returns to 00.
   - collision=1.
3. N=0, RAM[0x300..0x31F]=0xFF, x=0, y=0, plane=11. Required response:
   - 256 writes covering (0..15, 0..15), all 11.
   - busy stays high throughout.
   - Exactly one done pulse.
4. x=124, y=62, N=4, all bytes 0xFF, plane=10. Required response:
   - Without BLIT_WRAP_EN: only px 124-127, py 62-63 are written (8 writes).
   - With BLIT_WRAP_EN: 32 writes, including (0,0).
5. Assert reset low in the PIX_WR cycle of scenario 3. Required response:
   - vram_we=0 immediately.
   - busy=0 and collision=0.
   - A following start runs a complete draw normally.
6. Pulse start again while busy, and run a draw with plane=00. Required response:
   - The start during busy is ignored; exactly one done pulse.
   - The plane=00 draw makes zero VRAM writes, collision=0, and still gives done.
